// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP output serializer.
// Build option OUT_PARITY_EN appends an even-parity bit to every serial frame.
package msdap_pkg;

  localparam int DATA_W_DEF = 40;
  localparam int CNT_W_DEF  = 6;

`ifdef OUT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/msdap_p2s_chan.sv
// One serializer channel: one-deep pending buffer, sticky overrun flag, output shift register.
// With OUT_PARITY_EN defined the shift register carries the word's even parity as its final bit.
module msdap_p2s_chan
  import msdap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] acc,
  input  logic              load,
  input  logic              shift,
  input  logic              ovr_clr,
  output logic              pend_vld,
  output logic              ser_out,
  output logic              ovr
);

  localparam int SR_W = DATA_W + PAR_W;

  logic [DATA_W-1:0] pend_data_r;
  logic              pend_vld_r;
  logic              ovr_r;
  logic [SR_W-1:0]   shreg_r;
  logic [SR_W-1:0]   load_word_s;

`ifdef OUT_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  // Word presented to the shift register on a load: data followed by its parity bit
  always_comb load_word_s = {pend_data_r, even_parity(pend_data_r)};
`else
  // Word presented to the shift register on a load
  always_comb load_word_s = pend_data_r;
`endif

  // Pending buffer, overrun flag and shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data_r <= '0;
      pend_vld_r  <= 1'b0;
      ovr_r       <= 1'b0;
      shreg_r     <= '0;
    end else begin
      if (wr_en) begin
        pend_data_r <= acc;
      end
      // A write wins over consumption, so a same-cycle load+write keeps the buffer full
      if (wr_en) begin
        pend_vld_r <= 1'b1;
      end else if (load) begin
        pend_vld_r <= 1'b0;
      end
      // Set has priority over the synchronous clear
      if (wr_en && pend_vld_r && !load) begin
        ovr_r <= 1'b1;
      end else if (ovr_clr) begin
        ovr_r <= 1'b0;
      end
      if (load) begin
        shreg_r <= load_word_s;
      end else if (shift) begin
        shreg_r <= {shreg_r[SR_W-2:0], 1'b0};
      end
    end
  end

  assign pend_vld = pend_vld_r;
  assign ser_out  = shreg_r[SR_W-1];
  assign ovr      = ovr_r;

endmodule

// File: rtl/msdap_out_serializer.sv
// Dual-channel parallel-to-serial output stage: shared frame FSM and bit counter over two channels.
// Frame length is DATA_W bits, or DATA_W+1 when OUT_PARITY_EN is defined.
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Sclk,
  input  logic              Clear,
  input  logic              p2sL_en,
  input  logic              p2sR_en,
  input  logic [DATA_W-1:0] accL,
  input  logic [DATA_W-1:0] accR,
  input  logic              ovr_clr,
  output logic              OutputL,
  output logic              OutputR,
  output logic              OutReady,
  output logic              ovrL,
  output logic              ovrR
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W + PAR_W - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] bitcnt_r;
  logic [CNT_W-1:0] bitcnt_s;
  logic             load_s;
  logic             shift_s;
  logic             pend_l_vld_s;
  logic             pend_r_vld_s;
  logic             both_vld_s;

  assign both_vld_s = pend_l_vld_s & pend_r_vld_s;

  // Next-state, bit counter and shift-register control
  always_comb begin
    state_s  = state_r;
    bitcnt_s = bitcnt_r;
    load_s   = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (both_vld_s) begin
          load_s   = 1'b1;
          state_s  = SHIFT;
          bitcnt_s = LAST_CNT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        if (bitcnt_r == '0) begin
          if (both_vld_s) begin
            load_s   = 1'b1;
            bitcnt_s = LAST_CNT;
          end else begin
            // One more shift empties the registers so both lines idle at 0
            shift_s  = 1'b1;
            state_s  = IDLE;
          end
        end else begin
          shift_s  = 1'b1;
          bitcnt_s = bitcnt_r - 1'b1;
        end
      end
      default: begin
        state_s  = IDLE;
        bitcnt_s = '0;
      end
    endcase
  end

  // FSM state and bit counter registers
  always_ff @(posedge Sclk or posedge Clear) begin
    if (Clear) begin
      state_r  <= IDLE;
      bitcnt_r <= '0;
    end else begin
      state_r  <= state_s;
      bitcnt_r <= bitcnt_s;
    end
  end

  assign OutReady = (state_r == SHIFT);

  msdap_p2s_chan #(.DATA_W(DATA_W)) u_chan_l (
    .clk      (Sclk),
    .rst      (Clear),
    .wr_en    (p2sL_en),
    .acc      (accL),
    .load     (load_s),
    .shift    (shift_s),
    .ovr_clr  (ovr_clr),
    .pend_vld (pend_l_vld_s),
    .ser_out  (OutputL),
    .ovr      (ovrL)
  );

  msdap_p2s_chan #(.DATA_W(DATA_W)) u_chan_r (
    .clk      (Sclk),
    .rst      (Clear),
    .wr_en    (p2sR_en),
    .acc      (accR),
    .load     (load_s),
    .shift    (shift_s),
    .ovr_clr  (ovr_clr),
    .pend_vld (pend_r_vld_s),
    .ser_out  (OutputR),
    .ovr      (ovrR)
  );

endmodule
